// File: rtl/ft245_sync_ctrl.sv
`timescale 1ns/1ps
// FT2232H 245-style synchronous FIFO bridge.
// RX: host bytes are packed little-endian into WIDTH-bit words for the RX FIFO.
// TX: TX FIFO words are unpacked LSB byte first onto the chip bus.
// Everything runs on the chip's 60 MHz CLKOUT.
module ft245_sync_ctrl #(
  parameter  int WIDTH = 64,
  localparam int BYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ft_rxf_n,
  input  logic             ft_txe_n,
  input  logic [7:0]       ft_din,
  output logic [7:0]       ft_dout,
  output logic             ft_doe,
  output logic             ft_oe_n,
  output logic             ft_rd_n,
  output logic             ft_wr_n,
  output logic             rx_wr,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_full,
  output logic             tx_rd,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_empty
);

  localparam int            CW      = $clog2(BYTES + 1);
  localparam logic [CW-1:0] PK_LAST = CW'(BYTES - 1);
  localparam logic [CW-1:0] TX_FULL = CW'(BYTES);

  typedef enum logic [1:0] {IDLE, RX_TURN, RX, TX} state_t;

  state_t           state_q;
  logic             last_rx_q;   // last service granted was RX
  logic             run_q;       // low while in reset; keeps tx_rd quiet then
  logic [CW-1:0]    pk_cnt_q;
  logic [WIDTH-1:0] pk_sh_q;
  logic [WIDTH-1:0] pk_sh_d;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_pend_q;
  logic             fetch_q;     // tx_rd issued, word arrives on tx_data now
  logic [CW-1:0]    tx_cnt_q;
  logic [WIDTH-1:0] tx_sh_q;

  logic stall, rx_take, tx_live, tx_send, rx_ok, tx_ok, rx_wr_int, tx_rd_int;

  // rx_full is the RX FIFO's registered status flag; only the word-completing
  // byte is held back while a finished word still waits for space.
  assign stall     = rx_pend_q && rx_full && (pk_cnt_q == PK_LAST);
  assign rx_take   = (state_q == RX) && !stall && !ft_rxf_n;
  assign tx_live   = (tx_cnt_q != '0);
  assign tx_send   = (state_q == TX) && tx_live && !ft_txe_n;
  assign rx_ok     = !ft_rxf_n && !stall;
  assign tx_ok     = !ft_txe_n && tx_live;
  assign rx_wr_int = rx_pend_q && !rx_full;
  assign tx_rd_int = run_q && !tx_live && !fetch_q && !tx_empty;

  // Chip strobes decode from registered state and flags only.
  assign ft_oe_n = !((state_q == RX_TURN) || (state_q == RX));
  assign ft_rd_n = !((state_q == RX) && !stall);
  assign ft_wr_n = !((state_q == TX) && tx_live);
  assign ft_doe  = (state_q == TX);
  assign ft_dout = tx_sh_q[7:0];

  assign rx_wr   = rx_wr_int;
  assign rx_data = rx_data_q;
  assign tx_rd   = tx_rd_int;

  // Drop the incoming byte into the lane selected by the pack counter.
  always_comb begin
    pk_sh_d = pk_sh_q;
    for (int b = 0; b < BYTES; b++) begin
      if (pk_cnt_q == CW'(b)) pk_sh_d[8*b +: 8] = ft_din;
    end
  end

  // Bus arbitration: alternate RX/TX when both want the bus, RX first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_rx_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_ok && (!tx_ok || !last_rx_q)) begin
            state_q   <= RX_TURN;
            last_rx_q <= 1'b1;
          end else if (tx_ok) begin
            state_q   <= TX;
            last_rx_q <= 1'b0;
          end
        end
        RX_TURN: state_q <= RX;
        RX: if (ft_rxf_n || stall) state_q <= IDLE;
        TX: if (ft_txe_n || (!tx_live && !fetch_q && !tx_rd_int)) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // RX packing, word hand-off to the holding register and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_cnt_q  <= '0;
      pk_sh_q   <= '0;
      rx_data_q <= '0;
      rx_pend_q <= 1'b0;
    end else begin
      if (rx_wr_int) rx_pend_q <= 1'b0;
      if (rx_take) begin
        if (pk_cnt_q == PK_LAST) begin
          rx_data_q <= pk_sh_d;
          rx_pend_q <= 1'b1;
          pk_cnt_q  <= '0;
          pk_sh_q   <= '0;
        end else begin
          pk_sh_q   <= pk_sh_d;
          pk_cnt_q  <= pk_cnt_q + CW'(1);
        end
      end
    end
  end

  // TX fetch from the FIFO and byte-wise unpacking toward the chip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      fetch_q  <= 1'b0;
      tx_cnt_q <= '0;
      tx_sh_q  <= '0;
    end else begin
      run_q   <= 1'b1;
      fetch_q <= tx_rd_int;
      if (fetch_q) begin
        tx_sh_q  <= tx_data;
        tx_cnt_q <= TX_FULL;
      end else if (tx_send) begin
        tx_sh_q  <= tx_sh_q >> 8;
        tx_cnt_q <= tx_cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: doc/ft245_sync_ctrl.md
Name: ft245_sync_ctrl

Overview:
Bridges the FT2232H 245-style synchronous FIFO bus to the design's word-wide FIFOs.
- RX: host bytes are read from the chip, packed little-endian into WIDTH-bit words, and written into the RX FIFO's write port.
- TX: words are popped from the TX FIFO, unpacked LSB-byte first, and written to the chip.
- Runs entirely on the FT2232H 60 MHz CLKOUT (clk); all FIFO-side signals are synchronous to clk.

Parameters:
WIDTH, 64, FIFO word width in bits; must be a multiple of 8 and at least 8.
BYTES, WIDTH/8, bytes per word; derived, never overridden.

Ports:
clk  in  1  FT2232H CLKOUT, 60 MHz.
rst  in  1  reset, asynchronous, active-high.
ft_rxf_n  in  1  chip has RX data (low = available).
ft_txe_n  in  1  chip can accept TX data (low = space).
ft_din  in  8  data bus input.
ft_dout  out  8  data bus output.
ft_doe  out  1  bus output enable (1 = drive ft_dout).
ft_oe_n  out  1  chip output enable.
ft_rd_n  out  1  chip read strobe.
ft_wr_n  out  1  chip write strobe.
rx_wr  out  1  RX FIFO write strobe.
rx_data  out  WIDTH  RX FIFO write data.
rx_full  in  1  RX FIFO full.
tx_rd  out  1  TX FIFO read strobe.
tx_data  in  WIDTH  TX FIFO read data, valid the cycle after tx_rd.
tx_empty  in  1  TX FIFO empty.

Behaviour:
- Reset values (asynchronous): state=IDLE; ft_oe_n=ft_rd_n=ft_wr_n=1; ft_doe=0; ft_dout=0; rx_wr=0; rx_data=0; tx_rd=0. All counters, pending flags and shift registers are cleared.
- Reset mid-transfer: partial RX word and unsent TX bytes are discarded, strobes go high immediately, no FIFO strobe occurs.
- State machine:
  - IDLE. Go to RX_TURN if ft_rxf_n=0 and !stall. Otherwise go to TX if ft_txe_n=0 and tx_cnt!=0.
  - If both are eligible, alternate: serve the direction not served last; after reset, RX first.
  - RX_TURN: ft_oe_n=0, ft_rd_n=1, for exactly one cycle, then go to RX.
  - RX: ft_oe_n=0; ft_rd_n=0 while !stall. Go to IDLE at the first edge where ft_rxf_n=1 or stall=1.
  - TX: ft_doe=1; ft_wr_n=0 while tx_cnt!=0. Go to IDLE when ft_txe_n=1 or (tx_cnt==0 and no word arriving).
  - ft_doe and ft_oe_n=0 are never both asserted. RX->TX always passes through IDLE (one cycle of bus turnaround).
- Strobe timing: ft_rd_n, ft_wr_n and ft_oe_n are decoded combinationally from registered state and flags only; no input-to-output combinational path.
- RX byte acceptance:
  - A byte is accepted at an edge where ft_rd_n=0 and ft_rxf_n=0. ft_din is shifted into byte lane pk_cnt and pk_cnt increments.
  - When pk_cnt reaches BYTES, the word moves to the rx_data holding register, rx_pend=1, and pk_cnt=0.
  - rx_wr=1 for exactly one cycle in each cycle where rx_pend && !rx_full; rx_pend clears on that edge.
  - stall = rx_pend && rx_full && (pk_cnt==BYTES-1). Packing of the next word continues while a word is pending; only the completing byte is withheld.
- TX fetch:
  - When tx_cnt==0, no fetch is outstanding and !tx_empty, assert tx_rd for one cycle.
  - On the next edge, load tx_data into tx_sh and set tx_cnt=BYTES. This happens in any state.
- TX byte send:
  - ft_dout = tx_sh[7:0].
  - A byte is sent at an edge with ft_wr_n=0 and ft_txe_n=0; tx_sh then shifts right by 8 and tx_cnt decrements.
  - If ft_txe_n=1 at that edge, the byte is held and re-presented.
- BYTES=1: packing and unpacking degenerate to pass-through with the same handshakes.
- Throughput: sustained 1 byte/clk in each direction while the chip and FIFO allow, apart from the one-cycle fetch latency between TX words.

Test Plan:
1. Reset, then drive ft_rxf_n=0 with bytes 01..10 back-to-back, rx_full=0, WIDTH=64 -> ft_oe_n low 1 cycle before ft_rd_n. rx_wr pulses twice: rx_data=0x0807060504030201, then 0x100F0E0D0C0B0A09.
2. rx_full=1 throughout, stream 16 bytes -> exactly one word pending plus 7 bytes packed. ft_rd_n goes high before byte 16 and the state returns to IDLE. Release rx_full -> rx_wr pulses, RX resumes, second word = 0x100F0E0D0C0B0A09.
3. TX FIFO holds 0x1122334455667788, ft_txe_n=0 -> tx_rd pulse; ft_dout sequence 88,77,66,55,44,33,22,11 with ft_wr_n low for 8 consecutive accepted cycles.
4. Raise ft_txe_n for 3 cycles after byte 66 -> byte 55 held on ft_dout. After ft_txe_n drops, the remaining bytes 55..11 are sent with none lost or duplicated.
5. ft_rxf_n=0 and ft_txe_n=0 with TX data ready and RX-to-TX traffic alternating -> services alternate RX, TX, RX. ft_doe and ft_oe_n low never overlap, with at least one IDLE cycle between.
6. Assert rst mid-RX after 3 bytes and mid-TX after 2 bytes -> all strobes high and ft_doe=0 the same cycle, no rx_wr/tx_rd. The next RX word starts at byte lane 0.
